// File: rtl/pairing_result_reader_pkg.sv
// pairing_result_reader_pkg: shared pairing-core parameters and result reader FSM states
// Contents:
//   shared defines : WORD_SIZE, RAM_ADDR_SIZE, RAM_G, I_INPUTMODE_SIZE, EXEC_CORE, REF_RESULT
//   state_t        : reader FSM state encoding
// Optional feature macro: RESULT_READER_CHECKSUM_EN adds the SENDC state.
`ifndef PAIRING_PARAMS_SVH
`define PAIRING_PARAMS_SVH
`define WORD_SIZE 64
`define RAM_ADDR_SIZE 8
`define RAM_G 8'h40
`define I_INPUTMODE_SIZE 4
`define EXEC_CORE 4'd0
`define REF_RESULT 4'd6
`endif

package pairing_result_reader_pkg;
`ifdef RESULT_READER_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, WAIT_HI, WAIT_LO, ISSUE, CAPTURE, SEND0, SEND1, FIN, SENDC} state_t;
`else
  typedef enum logic [3:0] {IDLE, WAIT_HI, WAIT_LO, ISSUE, CAPTURE, SEND0, SEND1, FIN} state_t;
`endif
endpackage

// File: rtl/pairing_result_reader.sv
// pairing_result_reader: waits for one pairing-core run, then streams its NWORDS result words
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, is_busy          run request pulse, core busy flag
//   I_INPUTMODE             core mode (EXEC_CORE idle, REF_RESULT while reading)
//   I_RADDR1, I_RADDR2      core read addresses of the current word pair
//   outdata1, outdata2      core read data, valid one cycle after the address
//   o_data/o_valid/i_ready  result word stream, o_last marks its final word
//   o_done, o_active        end-of-run pulse, run in progress
// Optional feature macro: RESULT_READER_CHECKSUM_EN appends an XOR checksum word.
module pairing_result_reader
  import pairing_result_reader_pkg::*;
#(
  parameter int WORD_W = `WORD_SIZE,
  parameter int ADDR_W = `RAM_ADDR_SIZE,
  parameter logic [ADDR_W-1:0] BASE_ADDR = `RAM_G,
  parameter int NWORDS = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         is_busy,
  output logic [`I_INPUTMODE_SIZE-1:0] I_INPUTMODE,
  output logic [ADDR_W-1:0]            I_RADDR1,
  output logic [ADDR_W-1:0]            I_RADDR2,
  input  logic [WORD_W-1:0]            outdata1,
  input  logic [WORD_W-1:0]            outdata2,
  output logic [WORD_W-1:0]            o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_last,
  output logic                         o_done,
  output logic                         o_active
);
  localparam int NP = NWORDS / 2;
  localparam int KW = $clog2(NP + 1);
`ifdef RESULT_READER_CHECKSUM_EN
  localparam state_t AFTER_DATA = SENDC;
`else
  localparam state_t AFTER_DATA = FIN;
`endif
  state_t st, nxt;
  logic [KW-1:0] k;
  logic [WORD_W-1:0] buf0, buf1;
  logic [ADDR_W-1:0] addr;
  logic last_pair, rd;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [WORD_W-1:0] ck;
`endif
  assign last_pair = k == KW'(NP - 1);
  assign addr = BASE_ADDR + ADDR_W'({k, 1'b0});
  assign rd = st == ISSUE || st == CAPTURE;
  assign I_INPUTMODE = rd ? `REF_RESULT : `EXEC_CORE;
  assign I_RADDR1 = rd ? addr : '0;
  assign I_RADDR2 = rd ? addr + ADDR_W'(1) : '0;
  assign o_done = st == FIN;
  assign o_active = st != IDLE;
`ifdef RESULT_READER_CHECKSUM_EN
  assign o_valid = st == SEND0 || st == SEND1 || st == SENDC;
  assign o_data = st == SEND0 ? buf0 : st == SENDC ? ck : buf1;
  assign o_last = st == SENDC;
`else
  assign o_valid = st == SEND0 || st == SEND1;
  assign o_data = st == SEND0 ? buf0 : buf1;
  assign o_last = st == SEND1 && last_pair;
`endif
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? WAIT_HI : IDLE;
      WAIT_HI: nxt = is_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: nxt = is_busy ? WAIT_LO : ISSUE;
      ISSUE:   nxt = CAPTURE;
      CAPTURE: nxt = SEND0;
      SEND0:   nxt = i_ready ? SEND1 : SEND0;
      SEND1:   nxt = !i_ready ? SEND1 : last_pair ? AFTER_DATA : ISSUE;
`ifdef RESULT_READER_CHECKSUM_EN
      SENDC:   nxt = i_ready ? FIN : SENDC;
`endif
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      k <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE) k <= '0;
      else if (st == SEND1 && i_ready) k <= k + KW'(1);
      if (st == CAPTURE) begin
        buf0 <= outdata1;
        buf1 <= outdata2;
      end
    end
  end
`ifdef RESULT_READER_CHECKSUM_EN
  // running XOR of every captured word, cleared while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ck <= '0;
    else if (st == IDLE) ck <= '0;
    else if (st == CAPTURE) ck <= ck ^ outdata1 ^ outdata2;
  end
`endif
endmodule

// File: tb/tb_pairing_result_reader.sv
// tb_pairing_result_reader: randomized directed runs of the result reader against a word-list model
module tb_pairing_result_reader;
  localparam int W = `WORD_SIZE;
  localparam int A = `RAM_ADDR_SIZE;
  localparam int N = 12;
  localparam logic [A-1:0] BASE0 = `RAM_G;
  localparam logic [A-1:0] BASE1 = A'((1 << A) - 4);
`ifdef RESULT_READER_CHECKSUM_EN
  localparam int NE = N + 1;
`else
  localparam int NE = N;
`endif
  logic clk = 0, rst_n = 0;
  logic start[2], is_busy[2], i_ready[2];
  logic [`I_INPUTMODE_SIZE-1:0] mode[2];
  logic [A-1:0] ra1[2], ra2[2];
  logic [W-1:0] od1[2], od2[2], o_data[2], held[2];
  logic o_valid[2], o_last[2], o_done[2], o_active[2], stall[2];
  logic [W-1:0] mem [0:(1<<A)-1];
  logic [W:0] got[2][32];
  int ngot[2], done_cnt[2], hs_cyc[2], done_cyc[2];
  int cyc = 0, n_cmp = 0, n_err = 0;

  pairing_result_reader dut0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .is_busy(is_busy[0]),
    .I_INPUTMODE(mode[0]), .I_RADDR1(ra1[0]), .I_RADDR2(ra2[0]), .outdata1(od1[0]), .outdata2(od2[0]),
    .o_data(o_data[0]), .o_valid(o_valid[0]), .i_ready(i_ready[0]), .o_last(o_last[0]),
    .o_done(o_done[0]), .o_active(o_active[0]));
  pairing_result_reader #(.BASE_ADDR(BASE1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start[1]),
    .is_busy(is_busy[1]), .I_INPUTMODE(mode[1]), .I_RADDR1(ra1[1]), .I_RADDR2(ra2[1]),
    .outdata1(od1[1]), .outdata2(od2[1]), .o_data(o_data[1]), .o_valid(o_valid[1]),
    .i_ready(i_ready[1]), .o_last(o_last[1]), .o_done(o_done[1]), .o_active(o_active[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // core model: registered RAM read, data one cycle after the address
  always @(posedge clk)
    for (int s = 0; s < 2; s++) begin
      od1[s] <= mem[ra1[s]];
      od2[s] <= mem[ra2[s]];
    end

  // stream monitor: samples at negedge what the next posedge will transfer
  always @(negedge clk)
    for (int s = 0; s < 2; s++)
      if (rst_n) begin
        if (stall[s]) begin
          n_cmp++;
          assert (o_valid[s] === 1'b1 && o_data[s] === held[s]) else begin
            n_err++;
            $error("FAIL stall_hold dut%0d: observed v=%b d=%h expected v=1 d=%h", s, o_valid[s], o_data[s], held[s]);
          end
        end
        stall[s] = o_valid[s] && !i_ready[s];
        held[s] = o_data[s];
        if (o_valid[s] && i_ready[s]) begin
          if (ngot[s] < 32) got[s][ngot[s]] = {o_last[s], o_data[s]};
          ngot[s]++;
          hs_cyc[s] = cyc;
        end
        if (o_done[s]) begin
          done_cnt[s]++;
          done_cyc[s] = cyc;
        end
      end else stall[s] = 0;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int s);
    chk("rst_flags", {o_valid[s], o_last[s], o_done[s], o_active[s]}, '0);
    chk("rst_raddr", {ra1[s], ra2[s]}, '0);
    chk("rst_mode", mode[s], `EXEC_CORE);
    chk("rst_data", o_data[s], '0);
  endtask

  task automatic kick(input int s, input bit extra);
    tick();
    start[s] = 1;
    i_ready[s] = 1;
    @(negedge clk);
    chk("idle_start_ready_valid", o_valid[s], 0);
    tick();
    start[s] = 0;
    chk("wait_mode", mode[s], `EXEC_CORE);
    chk("wait_active", o_active[s], 1);
    tick();
    is_busy[s] = 1;
    tick();
    start[s] = extra;
    tick();
    start[s] = 0;
    tick();
    is_busy[s] = 0;
  endtask

  task automatic run(input int s, input bit stall_pat, input bit extra, input bit inc);
    logic [W-1:0] exp[NE];
    logic [W-1:0] x;
    logic [A-1:0] ad;
    int b;
    x = '0;
    for (int i = 0; i < N; i++) begin
      ad = (s != 0 ? BASE1 : BASE0) + A'(i);
      mem[ad] = inc ? W'(i + 1) : W'({$urandom, $urandom});
      exp[i] = mem[ad];
      x ^= exp[i];
    end
    if (NE > N) exp[NE-1] = x;
    ngot[s] = 0;
    done_cnt[s] = 0;
    kick(s, extra);
    b = 0;
    while (done_cnt[s] == 0 && b < 400) begin
      i_ready[s] = !stall_pat || (b % 4 == 0) || (b % 4 == 3);
      start[s] = extra && ngot[s] == 1 && o_valid[s];
      tick();
      b++;
    end
    start[s] = 0;
    i_ready[s] = 0;
    repeat (4) tick();
    chk("done_count", done_cnt[s], 1);
    chk("word_count", ngot[s], NE);
    chk("done_after_last", done_cyc[s], hs_cyc[s] + 1);
    chk("active_after", o_active[s], 0);
    for (int i = 0; i < NE && i < ngot[s]; i++)
      chk($sformatf("word%0d_dut%0d", i, s), got[s][i], {i == NE - 1, exp[i]});
  endtask

  task automatic reset_mid();
    int b;
    ngot[0] = 0;
    done_cnt[0] = 0;
    kick(0, 0);
    b = 0;
    while (!(ngot[0] == 4 && o_valid[0]) && b < 200) begin
      tick();
      b++;
    end
    chk("reached_send0_word4", {ngot[0] == 4, o_valid[0]}, 2'b11);
    rst_n = 0;
    #1;
    chk_reset(0);
    repeat (2) tick();
    rst_n = 1;
    i_ready[0] = 0;
    repeat (6) tick();
    chk("no_done_after_reset", done_cnt[0], 0);
    chk("idle_after_reset", o_active[0], 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start[s] = 0;
      is_busy[s] = 0;
      i_ready[s] = 0;
      ngot[s] = 0;
      done_cnt[s] = 0;
      stall[s] = 0;
    end
    for (int i = 0; i < (1 << A); i++) mem[i] = W'({$urandom, $urandom});
    #2;
    chk_reset(0);
    chk_reset(1);
    repeat (3) tick();
    rst_n = 1;
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 1, 0);
    reset_mid();
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 1, 1, 0);
    run(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
